ex3_to_bcd_seq: RTL and testbench

Sequential Excess-3 to BCD decoder, the receive end of the team's BCD-to-Excess-3 encode path. It accepts one 4-bit Excess-3 digit per valid/ready handshake and subtracts 3 from each. It packs NDIGITS decoded digits into one BCD word and presents that word on a valid/ready output port with a per-word error flag. It sits between a serial Excess-3 digit source and any packed-BCD consumer, such as display or arithmetic blocks.

---
 rtl/ex3_to_bcd_seq_if.sv | 33 +++
 rtl/ex3_to_bcd_seq.sv | 79 +++++++
 tb/tb_ex3_to_bcd_seq.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/ex3_to_bcd_seq_if.sv
// Handshake bundle for ex3_to_bcd_seq: serial Excess-3 digit input and packed BCD word output.
// slave is the decoder side, master is the digit source / word consumer side.
interface ex3_to_bcd_seq_if #(
  parameter int NDIGITS = 4
);
  logic                   in_valid;
  logic                   in_ready;
  logic [3:0]             ex3_in;
  logic                   out_valid;
  logic                   out_ready;
  logic [4*NDIGITS-1:0]   bcd_out;
  logic                   err;

  modport slave (
    input  in_valid,
    input  ex3_in,
    input  out_ready,
    output in_ready,
    output out_valid,
    output bcd_out,
    output err
  );

  modport master (
    output in_valid,
    output ex3_in,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  bcd_out,
    input  err
  );
endinterface

// File: rtl/ex3_to_bcd_seq.sv
// Sequential Excess-3 to BCD decoder: packs NDIGITS decoded digits into one word behind valid/ready.
// Define EX3_ERR_EN to flag illegal codes on err and store them as 4'h0.
module ex3_to_bcd_seq #(
  parameter int NDIGITS = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  ex3_to_bcd_seq_if.slave   bus
);
  localparam int W  = 4 * NDIGITS;
  localparam int CW = $clog2(NDIGITS + 1);

  typedef enum logic {COLLECT, HOLD} state_t;

  state_t          state;
  logic [CW-1:0]   cnt;
  logic [W-1:0]    shreg;
  logic            err_q;
  logic [3:0]      nib;
  logic            err_set;
  logic            accept;

  assign accept = bus.in_valid && (state == COLLECT);

`ifdef EX3_ERR_EN
  logic illegal;
  assign illegal = (bus.ex3_in < 4'h3) || (bus.ex3_in > 4'hC);
  assign nib     = illegal ? 4'h0 : (bus.ex3_in - 4'h3);
  assign err_set = illegal;
`else
  // Without range checking err_q can never set, so err is constant 0.
  assign nib     = bus.ex3_in - 4'h3;
  assign err_set = 1'b0;
`endif

  // clr outranks both an accept and a release in the same cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= COLLECT;
      cnt   <= '0;
      shreg <= '0;
      err_q <= 1'b0;
    end else if (clr) begin
      state <= COLLECT;
      cnt   <= '0;
      shreg <= '0;
      err_q <= 1'b0;
    end else begin
      case (state)
        COLLECT: begin
          if (accept) begin
            shreg <= (shreg << 4) | W'(nib);
            err_q <= err_q | err_set;
            if (cnt == CW'(NDIGITS - 1)) begin
              state <= HOLD;
              cnt   <= '0;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        HOLD: begin
          if (bus.out_ready) begin
            state <= COLLECT;
            shreg <= '0;
            err_q <= 1'b0;
          end
        end
        default: state <= COLLECT;
      endcase
    end
  end

  assign bus.in_ready  = (state == COLLECT);
  assign bus.out_valid = (state == HOLD);
  assign bus.bcd_out   = shreg;
  assign bus.err       = err_q;
endmodule

// File: tb/tb_ex3_to_bcd_seq.sv
// Directed scoreboard bench for ex3_to_bcd_seq with NDIGITS=4.
// Expected words are queued as digits are driven and popped when the DUT presents a word.
module tb_ex3_to_bcd_seq;
  logic clk;
  logic rst;
  logic clr;

  int n_checks = 0;
  int n_fail   = 0;
  logic [16:0] sb_q[$];

  ex3_to_bcd_seq_if #(.NDIGITS(4)) bus();

  ex3_to_bcd_seq #(.NDIGITS(4)) dut (
    .clk (clk),
    .rst (rst),
    .clr (clr),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    n_checks++;
    assert (observed === expected)
    else begin
      n_fail++;
      $error("[TB] FAIL %s: observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // Reference decode of four codes, first code in the top nibble; returns {err, bcd}.
  function automatic logic [16:0] model(input logic [15:0] codes);
    logic [15:0] b;
    logic        e;
    logic [3:0]  c;
    logic [3:0]  n;
    b = '0;
    e = 1'b0;
    for (int i = 3; i >= 0; i--) begin
      c = codes[i*4 +: 4];
`ifdef EX3_ERR_EN
      if (c < 4'h3 || c > 4'hC) begin
        n = 4'h0;
        e = 1'b1;
      end else begin
        n = c - 4'h3;
      end
`else
      n = c - 4'h3;
`endif
      b = {b[11:0], n};
    end
    return {e, b};
  endfunction

  task automatic applyStimulus(input logic [15:0] codes, input logic [15:0] exp_bcd,
                               input logic exp_err, input int gap);
    sb_q.push_back({exp_err, exp_bcd});
    for (int i = 3; i >= 0; i--) begin
      if (i == 0) check("early_valid", {31'd0, bus.out_valid}, 32'd0);
      bus.in_valid = 1'b1;
      bus.ex3_in   = codes[i*4 +: 4];
      tick();
      bus.in_valid = 1'b0;
      bus.ex3_in   = 4'h0;
      repeat (gap) tick();
    end
  endtask

  task automatic checkOutput(input string tag, input bit release_word);
    logic [16:0] exp;
    int waited;
    waited = 0;
    while (!bus.out_valid && waited < 8) begin
      tick();
      waited++;
    end
    check({tag, "_valid"}, {31'd0, bus.out_valid}, 32'd1);
    check({tag, "_ready_low"}, {31'd0, bus.in_ready}, 32'd0);
    check({tag, "_sb_nonempty"}, {31'd0, sb_q.size() == 0}, 32'd0);
    if (sb_q.size() != 0) begin
      exp = sb_q.pop_front();
      check({tag, "_bcd"}, {16'd0, bus.bcd_out}, {16'd0, exp[15:0]});
      check({tag, "_err"}, {31'd0, bus.err}, {31'd0, exp[16]});
    end
    if (release_word) begin
      bus.out_ready = 1'b1;
      tick();
      bus.out_ready = 1'b0;
      check({tag, "_valid_drop"}, {31'd0, bus.out_valid}, 32'd0);
      check({tag, "_ready_back"}, {31'd0, bus.in_ready}, 32'd1);
      check({tag, "_bcd_clear"}, {16'd0, bus.bcd_out}, 32'd0);
    end
  endtask

  initial begin
    logic [15:0] codes;
    logic [16:0] m;

    rst           = 1'b1;
    clr           = 1'b0;
    bus.in_valid  = 1'b0;
    bus.ex3_in    = 4'h0;
    bus.out_ready = 1'b0;
    tick();
    tick();
    check("rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
    check("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    check("rst_bcd", {16'd0, bus.bcd_out}, 32'd0);
    check("rst_err", {31'd0, bus.err}, 32'd0);
    rst = 1'b0;
    tick();

    $display("[TB] basic word");
    applyStimulus(16'h4567, 16'h1234, 1'b0, 0);
    checkOutput("basic", 1'b1);

    $display("[TB] boundary codes");
    applyStimulus(16'h3C3C, 16'h0909, 1'b0, 0);
    checkOutput("boundary", 1'b1);

    $display("[TB] illegal code");
`ifdef EX3_ERR_EN
    applyStimulus(16'h4F56, 16'h1023, 1'b1, 0);
`else
    applyStimulus(16'h4F56, 16'h1C23, 1'b0, 0);
`endif
    checkOutput("illegal", 1'b1);
    applyStimulus(16'h5678, 16'h2345, 1'b0, 0);
    checkOutput("clean_after", 1'b1);

    $display("[TB] input stalls");
    applyStimulus(16'hC876, 16'h9543, 1'b0, 3);
    checkOutput("stall", 1'b1);

    $display("[TB] backpressure");
    applyStimulus(16'h9A3B, 16'h6708, 1'b0, 0);
    for (int k = 0; k < 5; k++) begin
      bus.in_valid = k[0];
      bus.ex3_in   = 4'h7;
      check("bp_valid", {31'd0, bus.out_valid}, 32'd1);
      check("bp_ready", {31'd0, bus.in_ready}, 32'd0);
      check("bp_bcd", {16'd0, bus.bcd_out}, 32'h6708);
      tick();
    end
    bus.in_valid = 1'b0;
    checkOutput("bp", 1'b1);
    applyStimulus(16'h4444, 16'h1111, 1'b0, 0);
    checkOutput("bp_next", 1'b1);

    $display("[TB] async reset mid-word");
    bus.in_valid = 1'b1;
    bus.ex3_in   = 4'hA;
    tick();
    tick();
    bus.in_valid = 1'b0;
    check("pre_rst_bcd", {16'd0, bus.bcd_out}, 32'h0077);
    #2;
    rst = 1'b1;
    #1;
    check("arst_in_ready", {31'd0, bus.in_ready}, 32'd1);
    check("arst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    check("arst_bcd", {16'd0, bus.bcd_out}, 32'd0);
    check("arst_err", {31'd0, bus.err}, 32'd0);
    #2;
    rst = 1'b0;
    tick();
    applyStimulus(16'h7B5C, 16'h4829, 1'b0, 0);
    checkOutput("after_rst", 1'b1);

    $display("[TB] clr mid-word");
    bus.in_valid = 1'b1;
    bus.ex3_in   = 4'h6;
    tick();
    tick();
    bus.ex3_in = 4'h8;
    clr        = 1'b1;
    tick();
    clr          = 1'b0;
    bus.in_valid = 1'b0;
    check("clr_bcd", {16'd0, bus.bcd_out}, 32'd0);
    check("clr_in_ready", {31'd0, bus.in_ready}, 32'd1);
    applyStimulus(16'h3456, 16'h0123, 1'b0, 0);
    checkOutput("after_clr", 1'b1);

    $display("[TB] clr in HOLD");
    applyStimulus(16'h8888, 16'h5555, 1'b0, 0);
    clr           = 1'b1;
    bus.out_ready = 1'b1;
    tick();
    clr           = 1'b0;
    bus.out_ready = 1'b0;
    check("clr_hold_valid", {31'd0, bus.out_valid}, 32'd0);
    check("clr_hold_bcd", {16'd0, bus.bcd_out}, 32'd0);
    void'(sb_q.pop_front());

    $display("[TB] random words");
    for (int k = 0; k < 6; k++) begin
      codes = 16'($urandom_range(0, 65535));
      m = model(codes);
      applyStimulus(codes, m[15:0], m[16], k % 2);
      checkOutput("rand", 1'b1);
    end

    $display("[TB] End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
